// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - phase encodings and light-decode constants for traffic_ctrl_param
package traffic_pkg;

  localparam logic [2:0] ST_HG  = 3'd0;
  localparam logic [2:0] ST_HY  = 3'd1;
  localparam logic [2:0] ST_SG  = 3'd2;
  localparam logic [2:0] ST_SY  = 3'd3;
  localparam logic [2:0] ST_AR1 = 3'd4;
  localparam logic [2:0] ST_AR2 = 3'd5;

  // Bit order: {green_main, yellow_main, red_main, green_sec, yellow_sec, red_sec}
  localparam logic [5:0] LT_HG = 6'b100_001;
  localparam logic [5:0] LT_HY = 6'b010_001;
  localparam logic [5:0] LT_SG = 6'b001_100;
  localparam logic [5:0] LT_SY = 6'b001_010;
  localparam logic [5:0] LT_AR = 6'b001_001;

  function automatic logic [5:0] lights_of(input logic [2:0] st);
    case (st)
      ST_HG:   return LT_HG;
      ST_HY:   return LT_HY;
      ST_SG:   return LT_SG;
      ST_SY:   return LT_SY;
      default: return LT_AR;
    endcase
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// rtl/sec_tick_gen.sv - prescaler producing a one-cycle tick every CLK_HZ cycles
module sec_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(CLK_HZ);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(CLK_HZ - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_ctrl_param.sv
// rtl/traffic_ctrl_param.sv - highway/secondary traffic controller; TRAFFIC_ALL_RED_EN adds all-red clearance
module traffic_ctrl_param
  import traffic_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int T_HG     = 15,
  parameter int T_HY     = 2,
  parameter int T_SG     = 5,
  parameter int T_SG_MIN = 2,
  parameter int T_SY     = 2,
  parameter int T_AR     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor,
  output logic       green_main,
  output logic       yellow_main,
  output logic       red_main,
  output logic       green_secondary,
  output logic       yellow_secondary,
  output logic       red_secondary,
  output logic [7:0] sec_left,
  output logic [2:0] phase,
  output logic       sec_tick
);

  if (CLK_HZ < 2 || T_HG < 1 || T_HG > 255 || T_HY < 1 || T_HY > 255 ||
      T_SG < 1 || T_SG > 255 || T_SG_MIN < 1 || T_SG_MIN > T_SG ||
      T_SY < 1 || T_SY > 255 || T_AR < 1 || T_AR > 255) begin : g_param_err
    $error("traffic_ctrl_param: parameter out of range");
  end

  localparam logic [7:0] T_HG8     = 8'(T_HG);
  localparam logic [7:0] T_HY8     = 8'(T_HY);
  localparam logic [7:0] T_SG8     = 8'(T_SG);
  localparam logic [7:0] T_SG_MIN8 = 8'(T_SG_MIN);
  localparam logic [7:0] T_SY8     = 8'(T_SY);
  localparam logic [7:0] T_AR8     = 8'(T_AR);

  logic       sens_m, sens_s;
  logic [2:0] state, next_state;
  logic [7:0] entry_len;
  logic       tick, expire, changing;

  always_ff @(posedge clk) begin
    if (rst) begin
      sens_m <= 1'b0;
      sens_s <= 1'b0;
    end else begin
      sens_m <= sensor;
      sens_s <= sens_m;
    end
  end

  // Restarting the prescaler on every transition makes each timed phase exactly T*CLK_HZ cycles.
  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (changing),
    .tick (tick)
  );

  assign expire   = tick && (sec_left == 8'd1);
  assign changing = (next_state != state);

  always_comb begin
    next_state = state;
    case (state)
      ST_HG: if (sec_left == 8'd0 && sens_s) next_state = ST_HY;
`ifdef TRAFFIC_ALL_RED_EN
      ST_HY:  if (expire) next_state = ST_AR1;
      ST_SY:  if (expire) next_state = ST_AR2;
      ST_AR1: if (expire) next_state = ST_SG;
      ST_AR2: if (expire) next_state = ST_HG;
`else
      ST_HY:  if (expire) next_state = ST_SG;
      ST_SY:  if (expire) next_state = ST_HG;
`endif
      // Early release once the minimum green has elapsed in whole seconds.
      ST_SG: if (expire || (!sens_s && (T_SG8 - sec_left) >= T_SG_MIN8)) next_state = ST_SY;
      default: next_state = ST_HG;
    endcase
  end

  always_comb begin
    entry_len = T_AR8;
    case (next_state)
      ST_HG:   entry_len = T_HG8;
      ST_HY:   entry_len = T_HY8;
      ST_SG:   entry_len = T_SG8;
      ST_SY:   entry_len = T_SY8;
      default: entry_len = T_AR8;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_HG;
      sec_left <= T_HG8;
    end else if (changing) begin
      state    <= next_state;
      sec_left <= entry_len;
    end else if (tick && sec_left != 8'd0) begin
      sec_left <= sec_left - 8'd1;
    end
  end

  assign {green_main, yellow_main, red_main,
          green_secondary, yellow_secondary, red_secondary} = lights_of(state);
  assign phase    = state;
  assign sec_tick = tick;

endmodule
